// File: rtl/muldiv_if.sv
// Handshake bundle between the EX stage and the iterative multiply/divide unit.
// Signal names follow the original flat port list so the port map is unchanged.
interface muldiv_if #(
    parameter int unsigned XLEN = 32
);
    logic            valid_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            kill_i;
    logic            stall_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output valid_i, funct3_i, rs1_i, rs2_i, kill_i,
        input  stall_o, done_o, result_o
    );

    modport slave (
        input  valid_i, funct3_i, rs1_i, rs2_i, kill_i,
        output stall_o, done_o, result_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on magnitudes, with
// sign correction applied on the final step. Stalls EX until the result is ready.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);
    localparam int unsigned     CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc, acc_step, mul_step, div_step, prod;
    logic [XLEN-1:0]   opd, result_q, mag_a, mag_b, spec_res, quo, rem, final_res;
    logic [XLEN:0]     mul_sum, div_cand, div_diff;
    logic [2:0]        op_q;
    logic              neg_q, rneg_q;
    logic              is_div, sgn_a, sgn_b, neg_a, neg_b;
    logic              div_zero, div_ovf, spec_case, start, finish;

    // Operand decode for the instruction currently in EX
    always_comb begin
        is_div    = bus.funct3_i[2];
        sgn_a     = (bus.funct3_i == 3'd1) || (bus.funct3_i == 3'd2) ||
                    (bus.funct3_i == 3'd4) || (bus.funct3_i == 3'd6);
        sgn_b     = (bus.funct3_i == 3'd1) || (bus.funct3_i == 3'd4) ||
                    (bus.funct3_i == 3'd6);
        neg_a     = sgn_a & bus.rs1_i[XLEN-1];
        neg_b     = sgn_b & bus.rs2_i[XLEN-1];
        mag_a     = neg_a ? -bus.rs1_i : bus.rs1_i;
        mag_b     = neg_b ? -bus.rs2_i : bus.rs2_i;
        div_zero  = is_div && (bus.rs2_i == '0);
        div_ovf   = is_div && !bus.funct3_i[0] && (bus.rs1_i == MIN_INT) && (bus.rs2_i == '1);
        spec_case = div_zero || div_ovf;
        if (div_zero) spec_res = bus.funct3_i[1] ? bus.rs1_i : '1;
        else          spec_res = bus.funct3_i[1] ? '0 : MIN_INT;
    end

    // acc holds {partial product high, multiplier} for MUL and
    // {remainder, dividend/quotient} for DIV; opd is the other magnitude.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
        mul_step = {mul_sum, acc[XLEN-1:1]};
        div_cand = acc[2*XLEN-1:XLEN-1];
        div_diff = div_cand - {1'b0, opd};
        div_step = div_diff[XLEN] ? {div_cand[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                  : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        acc_step = op_q[2] ? div_step : mul_step;
        prod     = neg_q  ? -acc_step : acc_step;
        quo      = neg_q  ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        rem      = rneg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
        case (op_q)
            3'd0:               final_res = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3:   final_res = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:         final_res = quo;
            default:            final_res = rem;
        endcase
    end

    always_comb begin
        state_n = state;
        start   = 1'b0;
        finish  = 1'b0;
        if (bus.kill_i) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (bus.valid_i) begin
                    start   = 1'b1;
                    state_n = spec_case ? DONE : CALC;
                end
                CALC: if (cnt == CNT_LAST) begin
                    finish  = 1'b1;
                    state_n = DONE;
                end
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            opd      <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state <= state_n;
            if (start) begin
                op_q   <= bus.funct3_i;
                neg_q  <= neg_a ^ neg_b;
                rneg_q <= neg_a;
                cnt    <= '0;
                acc    <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                opd    <= is_div ? mag_b : mag_a;
                if (spec_case) result_q <= spec_res;
            end else if (state == CALC) begin
                acc <= acc_step;
                cnt <= cnt + CW'(1);
                if (finish) result_q <= final_res;
            end
        end
    end

    assign bus.stall_o  = rst_n & bus.valid_i & ~bus.kill_i & (state != DONE);
    assign bus.done_o   = (state == DONE);
    assign bus.result_o = result_q;
endmodule
